// File: rtl/noc_resp_sink_if.sv
// Flit bus from the NSU response path into the response sink.
//   nocdata   : flit payload, bit DATA_WIDTH is the flit valid
//   m_is_head : head marker, meaningful only when the flit is valid
//   m_is_tail : tail marker, meaningful only when the flit is valid
// master drives the flits (NSU or bench); slave is the sink side.
interface noc_resp_sink_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH:0] nocdata;
  logic                m_is_head;
  logic                m_is_tail;

  modport master (output nocdata, m_is_head, m_is_tail);
  modport slave  (input  nocdata, m_is_head, m_is_tail);
endinterface

// File: rtl/noc_resp_sink.sv
// Response-side endpoint of the NSU bench path. Parses write-response and
// read-data packets, checks framing, head fields, per-VC tag order and the
// deterministic read payload, and keeps counters plus sticky error status.
// It never backpressures.
// Ports:
//   noc_clk, noc_rst : clock, asynchronous active-high reset
//   rx               : flit bus (slave modport)
//   clr_stats        : synchronous clear of counters, error state, tag trackers
//   rx_busy          : inside a read packet (state BODY)
//   wr_resp_cnt      : good write responses (saturating)
//   rd_resp_cnt      : good read responses (saturating)
//   err_cnt          : erroneous flits (saturating)
//   err_flag         : sticky error indicator
//   err_code, err_vc : code and VC of the first error since reset/clear
module noc_resp_sink #(
  parameter  int DATA_WIDTH     = 128,
  parameter  int ID_WIDTH       = 4,
  parameter  int VIRTUAL_CH_NUM = 16,
  parameter  int FLIT_NUM_MAX   = 16,
  parameter  int MY_ID          = 0,
  localparam int VC_W           = (VIRTUAL_CH_NUM > 1) ? $clog2(VIRTUAL_CH_NUM) : 1
)(
  input  logic                 noc_clk,
  input  logic                 noc_rst,
  noc_resp_sink_if.slave       rx,
  input  logic                 clr_stats,
  output logic                 rx_busy,
  output logic [31:0]          wr_resp_cnt,
  output logic [31:0]          rd_resp_cnt,
  output logic [15:0]          err_cnt,
  output logic                 err_flag,
  output logic [3:0]           err_code,
  output logic [VC_W-1:0]      err_vc
);

  localparam logic [ID_WIDTH-1:0] MY_DEST = ID_WIDTH'(MY_ID);
  localparam logic [7:0]          LEN_MAX = 8'(FLIT_NUM_MAX);

  typedef enum logic [0:0] {IDLE, BODY} state_t;

  state_t                              state;
  logic                                discard;   // missing tail seen: drop flits until a tail
  logic                                pkt_err;   // current read packet already has an error
  logic [VC_W-1:0]                     cur_vc;
  logic [11:0]                         cur_tag;
  logic [7:0]                          cur_len;
  logic [7:0]                          beat;
  logic [VIRTUAL_CH_NUM-1:0][11:0]     exp_tag;
  // A VC's tracker is only meaningful after its first accepted head, so the
  // first tag seen on a VC after reset/clear just synchronises it.
  logic [VIRTUAL_CH_NUM-1:0]           tag_seen;

  // Flit decode; markers only count on valid flits.
  logic                  flit_vld, head, tail, in_body, last;
  logic [ID_WIDTH-1:0]   h_dest;
  logic [VC_W-1:0]       h_vc;
  logic [7:0]            h_len;
  logic [1:0]            h_type, h_resp;
  logic [11:0]           h_tag;
  logic                  hd_wr, hd_rd, hd_accept, hd_err;
  logic [DATA_WIDTH-1:0] exp_pat;

  assign flit_vld = rx.nocdata[DATA_WIDTH];
  assign head     = flit_vld & rx.m_is_head;
  assign tail     = flit_vld & rx.m_is_tail;
  assign in_body  = (state == BODY);
  assign last     = (beat == cur_len - 8'd1);

  assign h_dest = rx.nocdata[ID_WIDTH-1:0];
  assign h_vc   = rx.nocdata[4+VC_W-1:4];
  assign h_len  = rx.nocdata[15:8];
  assign h_type = rx.nocdata[17:16];
  assign h_resp = rx.nocdata[19:18];
  assign h_tag  = rx.nocdata[31:20];

  assign exp_pat = {(DATA_WIDTH/32){4'hA, cur_tag, 8'h00, beat}};

  // Error conditions for the flit on the bus this cycle
  logic e_idle1, e_abort2, e_early3, e_notail4, e_data5;
  logic e_resp6, e_type7, e_len8, e_dest9, e_tag10;
  logic body_flit, flit_err;
  logic [3:0]      code;
  logic [VC_W-1:0] code_vc;

  assign hd_wr     = (h_type == 2'b00);
  assign hd_rd     = (h_type == 2'b01);
  assign e_type7   = head & (~(hd_wr | hd_rd) | (hd_wr & ((h_len != 8'd0) | ~tail)));
  assign e_len8    = head & hd_rd & ((h_len == 8'd0) | (h_len > LEN_MAX));
  assign hd_accept = head & ~e_type7 & ~e_len8;
  assign e_dest9   = head & (h_dest != MY_DEST);
  assign e_resp6   = head & (h_resp != 2'b00);
  assign e_tag10   = hd_accept & tag_seen[h_vc] & (h_tag != exp_tag[h_vc]);
  assign hd_err    = e_dest9 | e_resp6 | e_tag10;

  assign body_flit = flit_vld & ~rx.m_is_head & in_body & ~discard;
  assign e_idle1   = flit_vld & ~rx.m_is_head & ~in_body;
  assign e_abort2  = head & in_body;
  assign e_early3  = body_flit & tail & ~last;
  assign e_notail4 = body_flit & ~tail & last;
  assign e_data5   = body_flit & (rx.nocdata[DATA_WIDTH-1:0] != exp_pat);

  assign flit_err = e_idle1 | e_abort2 | e_early3 | e_notail4 | e_data5 |
                    e_resp6 | e_type7 | e_len8 | e_dest9 | e_tag10;

  // Lowest code wins when one flit trips several checks.
  always_comb begin
    code = 4'd0;
    if (e_tag10)   code = 4'd10;
    if (e_dest9)   code = 4'd9;
    if (e_len8)    code = 4'd8;
    if (e_type7)   code = 4'd7;
    if (e_resp6)   code = 4'd6;
    if (e_data5)   code = 4'd5;
    if (e_notail4) code = 4'd4;
    if (e_early3)  code = 4'd3;
    if (e_abort2)  code = 4'd2;
    if (e_idle1)   code = 4'd1;
  end

  // An abort is blamed on the packet being cut off, not on the new head.
  assign code_vc = (head & ~e_abort2) ? h_vc : cur_vc;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state       <= IDLE;
      rx_busy     <= 1'b0;
      discard     <= 1'b0;
      pkt_err     <= 1'b0;
      cur_vc      <= '0;
      cur_tag     <= '0;
      cur_len     <= '0;
      beat        <= '0;
      exp_tag     <= '0;
      tag_seen    <= '0;
      wr_resp_cnt <= '0;
      rd_resp_cnt <= '0;
      err_cnt     <= '0;
      err_flag    <= 1'b0;
      err_code    <= '0;
      err_vc      <= '0;
    end else if (clr_stats) begin
      state       <= IDLE;
      rx_busy     <= 1'b0;
      discard     <= 1'b0;
      pkt_err     <= 1'b0;
      beat        <= '0;
      exp_tag     <= '0;
      tag_seen    <= '0;
      wr_resp_cnt <= '0;
      rd_resp_cnt <= '0;
      err_cnt     <= '0;
      err_flag    <= 1'b0;
      err_code    <= '0;
      err_vc      <= '0;
    end else begin
      if (flit_err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        if (!err_flag) begin
          err_flag <= 1'b1;
          err_code <= code;
          err_vc   <= code_vc;
        end
      end

      if (head) begin
        // A head always starts afresh, whatever state we were in.
        discard <= 1'b0;
        if (hd_accept) begin
          exp_tag[h_vc]  <= h_tag + 12'd1;
          tag_seen[h_vc] <= 1'b1;
        end
        if (hd_accept && hd_wr && !hd_err && wr_resp_cnt != '1)
          wr_resp_cnt <= wr_resp_cnt + 32'd1;
        if (hd_accept && hd_rd) begin
          state   <= BODY;
          rx_busy <= 1'b1;
          cur_vc  <= h_vc;
          cur_tag <= h_tag;
          cur_len <= h_len;
          beat    <= '0;
          pkt_err <= hd_err;
        end else begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      end else if (flit_vld && in_body) begin
        if (tail) begin
          state   <= IDLE;
          rx_busy <= 1'b0;
          discard <= 1'b0;
          if (!discard && last && !pkt_err && !e_data5 && rd_resp_cnt != '1)
            rd_resp_cnt <= rd_resp_cnt + 32'd1;
        end else if (!discard) begin
          if (last) begin
            discard <= 1'b1;
          end else begin
            beat <= beat + 8'd1;
            if (e_data5) pkt_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/noc_resp_sink.md
Name: noc_resp_sink

Overview:
- Response-side endpoint of the NSU bench path: consumes the flit stream the NSU returns on nocdata / m_is_head / m_is_tail (write responses and read-data packets) in the noc_clk domain.
- Parses packets and checks framing, header fields, per-VC tag order and read payload against the deterministic pattern the bench generator writes.
- Exposes counters and sticky error status for hardware self-test on the board.
- Pure sink: it never applies backpressure.

Parameters:
DATA_WIDTH, 128, flit payload width; nocdata is DATA_WIDTH+1 bits with bit DATA_WIDTH = flit valid; must be a multiple of 32.
ID_WIDTH, 4, node ID width.
VIRTUAL_CH_NUM, 16, number of VCs; VC field width VC_W = clog2(VIRTUAL_CH_NUM).
FLIT_NUM_MAX, 16, maximum payload flits per read response.
MY_ID, 0, expected destination ID in head flits.

Ports:
noc_clk  input  1  NoC clock.
noc_rst  input  1  asynchronous active-high reset.
nocdata  input  DATA_WIDTH+1  flit; [DATA_WIDTH] = valid.
m_is_head  input  1  head marker, qualified by valid.
m_is_tail  input  1  tail marker, qualified by valid.
clr_stats  input  1  synchronous clear of counters, error status and tag trackers.
rx_busy  output  1  high while inside a read packet (state BODY).
wr_resp_cnt  output  32  good write responses received.
rd_resp_cnt  output  32  good read responses received.
err_cnt  output  16  erroneous flits.
err_flag  output  1  sticky, set by any error.
err_code  output  4  code of the first error since reset/clear.
err_vc  output  VC_W  VC of the first error.

Behaviour:
- Head fields: [ID_WIDTH-1:0] dest; [4+VC_W-1:4] vc; [15:8] len L (payload flits); [17:16] type (00 write resp, 01 read resp); [19:18] resp; [31:20] tag.
- Payload beat k (0-based) of tag T = 32-bit word {4'hA, T[11:0], 8'h00, k[7:0]} replicated DATA_WIDTH/32 times.
- Flits with valid=0 are ignored entirely; head/tail markers are ignored in those cycles.
- FSM IDLE/BODY, all outputs registered. Reset: state IDLE, every counter 0, err_flag 0, err_code 0, err_vc 0, rx_busy 0, tag trackers 0.
- IDLE, head flit:
  - Type 00 must have L=0 and tail in the same cycle.
  - Type 01 with L>=1 latches vc, tag and L, clears the beat counter and goes to BODY.
- BODY, per valid non-head flit:
  - Compare data against the expected pattern.
  - beat==L-1 requires tail: return to IDLE and increment rd_resp_cnt if no error occurred in the packet.
  - Tail with beat<L-1: code 3, packet ends, IDLE.
- Per-VC expected tag: array of VIRTUAL_CH_NUM x 12 bits. On each accepted head, set it to tag+1 (wraps 0xFFF->0x000). A mismatching tag still resyncs the tracker.
- Error codes:
  - 1: non-head flit in IDLE.
  - 2: head in BODY; the current packet is aborted and the new head is processed normally in the same cycle.
  - 3: early tail.
  - 4: missing tail at beat L-1; the FSM stays in BODY and discards flits until a tail.
  - 5: data mismatch.
  - 6: resp!=00.
  - 7: type not 00/01, or type 00 with L!=0 or no tail.
  - 8: L==0 for type 01, or L>FLIT_NUM_MAX. Codes 7 and 8 drop the packet and return/stay in IDLE.
  - 9: dest!=MY_ID.
  - 10: tag out of order.
- A packet with any error is not counted good. Several errors in one flit: err_cnt +1 only, and the lowest code is the one reported.
- err_code/err_vc capture only when err_flag is 0. err_flag is sticky until clr_stats or reset.
- Latency: counters and err_* update on the clock edge that samples the flit (visible the next cycle).
- Counters saturate: 32-bit at 0xFFFFFFFF, err_cnt at 0xFFFF.
- clr_stats has priority over a same-cycle count update and forces IDLE.
- Reset mid-packet returns to IDLE with no count.

Test Plan:
- Write resp head dest=0, vc=3, L=0, type 00, resp 00, tag 0, head+tail -> wr_resp_cnt=1, err_flag=0.
- Read resp vc=5, tag 0x012, L=4, correct beats 0..3, tail on beat 3 -> rd_resp_cnt=1, rx_busy high for 4 cycles.
- Same packet with beat 2 bit 0 flipped -> err_cnt=1, err_code=5, err_vc=5, rd_resp_cnt unchanged.
- Head L=4 with tail on beat 1, then a valid packet -> err_code=3, next packet counted, err_cnt=1.
- vc=7 tags 0x000, 0x001, 0x003, 0x004 -> one code-10 error on 0x003, no error on 0x004; tag 0xFFF then 0x000 -> no error.
- Head while in BODY plus L=17 head -> codes 2 then 8; err_code stays 2, err_cnt=2; clr_stats -> all zero.
